// File: rtl/idma_legacy_mchan_arbiter.sv
// Round-robin front end that merges several legacy 1D burst request ports onto
// one backend. It tracks which channel owns each in-flight transfer and routes each completion back.

package idma_legacy_mchan_pkg;

   typedef struct packed {
      logic [31:0] num_bytes;
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic        decouple_rw;
      logic        deburst;
      logic        serialize;
   } burst_req_t;

endpackage

// Handshakes: a channel transfer happens in a cycle where chan_valid_i[c] and
// chan_ready_o[c] are both high; a backend transfer happens in a cycle where
// be_valid_o and be_ready_i are both high. be_req_o is held while be_valid_o && !be_ready_i.
module idma_legacy_mchan_arbiter #(
   parameter int unsigned NumChan    = 4,
   parameter int unsigned TrackDepth = 8,
   parameter type         burst_req_t = idma_legacy_mchan_pkg::burst_req_t,
   parameter int unsigned CntWidth   = $clog2(TrackDepth + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  burst_req_t [NumChan-1:0]           chan_req_i,
   input  logic [NumChan-1:0]                 chan_valid_i,
   output logic [NumChan-1:0]                 chan_ready_o,
   output logic [NumChan-1:0]                 chan_complete_o,
   output logic [NumChan-1:0][CntWidth-1:0]   chan_outstanding_o,
   output logic [NumChan-1:0]                 chan_idle_o,
   output burst_req_t                         be_req_o,
   output logic                               be_valid_o,
   input  logic                               be_ready_i,
   input  logic                               be_complete_i,
   input  logic                               be_idle_i,
   output logic                               idle_o,
   output logic                               err_o
);

   localparam int unsigned IdxW = $clog2(NumChan);
   localparam int unsigned PtrW = $clog2(TrackDepth);

   logic [IdxW-1:0]                 rr_q, rr_d;
   logic                            be_valid_q;
   burst_req_t                      be_req_q;
   logic [CntWidth-1:0]             occ_q;
   logic [PtrW-1:0]                 wr_ptr_q, rd_ptr_q;
   logic [IdxW-1:0]                 track_mem [TrackDepth];
   logic [NumChan-1:0][CntWidth-1:0] outst_q;
   logic [NumChan-1:0]              complete_q;
   logic                            err_q;

   logic                            reg_free;
   logic                            track_room;
   logic                            pop;
   logic [IdxW-1:0]                 head;
   logic [NumChan-1:0]              nonzero;
   logic [NumChan-1:0]              eligible;
   logic                            grant_found;
   logic [IdxW-1:0]                 grant_idx;
   logic [IdxW-1:0]                 cand_idx;
   int unsigned                     cand;
   logic                            push;
   logic                            grant_zero;
   logic [NumChan-1:0]              inc_vec;
   logic [NumChan-1:0]              dec_vec;
   logic [NumChan-1:0]              zero_vec;

   assign reg_free   = !be_valid_q || be_ready_i;
   // A completion in the same cycle frees the slot a full tracker needs.
   assign track_room = (occ_q != CntWidth'(TrackDepth)) || be_complete_i;
   assign pop        = be_complete_i && (occ_q != '0);
   assign head       = track_mem[rd_ptr_q];

   always_comb begin
      nonzero  = '0;
      eligible = '0;
      for (int c = 0; c < NumChan; c++) begin
         nonzero[c]  = (chan_req_i[c].num_bytes != '0);
         // Zero-length requests wait for the channel to drain so pulses stay in order.
         eligible[c] = !rst_i && chan_valid_i[c] &&
                       (nonzero[c] ? (reg_free && track_room) : (outst_q[c] == '0));
      end
   end

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < NumChan; i++) begin
         cand     = (int'(rr_q) + i) % NumChan;
         cand_idx = IdxW'(cand);
         if (!grant_found && eligible[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant_found) begin
         rr_d = (grant_idx == IdxW'(NumChan - 1)) ? '0 : grant_idx + IdxW'(1);
      end
   end

   assign push       = grant_found && nonzero[grant_idx];
   assign grant_zero = grant_found && !nonzero[grant_idx];

   always_comb begin
      chan_ready_o = '0;
      inc_vec      = '0;
      dec_vec      = '0;
      zero_vec     = '0;
      if (grant_found) chan_ready_o[grant_idx] = 1'b1;
      if (push)        inc_vec[grant_idx]      = 1'b1;
      if (grant_zero)  zero_vec[grant_idx]     = 1'b1;
      if (pop)         dec_vec[head]           = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         be_valid_q <= 1'b0;
         be_req_q   <= '0;
         occ_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         outst_q    <= '0;
         complete_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         complete_q <= zero_vec | dec_vec;
         if (push) begin
            be_valid_q <= 1'b1;
            be_req_q   <= chan_req_i[grant_idx];
            wr_ptr_q   <= wr_ptr_q + PtrW'(1);
         end else if (be_ready_i) begin
            be_valid_q <= 1'b0;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + CntWidth'(1);
            2'b01:   occ_q <= occ_q - CntWidth'(1);
            default: occ_q <= occ_q;
         endcase
         for (int c = 0; c < NumChan; c++) begin
            if (inc_vec[c] && !dec_vec[c]) begin
               outst_q[c] <= outst_q[c] + CntWidth'(1);
            end else if (dec_vec[c] && !inc_vec[c]) begin
               outst_q[c] <= outst_q[c] - CntWidth'(1);
            end
         end
         if (be_complete_i && (occ_q == '0)) err_q <= 1'b1;
      end
   end

   // Tracker storage needs no reset: occupancy and pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push) track_mem[wr_ptr_q] <= grant_idx;
   end

   always_comb begin
      chan_idle_o = '0;
      for (int c = 0; c < NumChan; c++) begin
         chan_idle_o[c] = (outst_q[c] == '0) && !complete_q[c];
      end
   end

   assign chan_complete_o    = complete_q;
   assign chan_outstanding_o = outst_q;
   assign be_req_o           = be_req_q;
   assign be_valid_o         = be_valid_q;
   assign idle_o             = (&chan_idle_o) && be_idle_i && !be_valid_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_idma_legacy_mchan_arbiter.sv
// Directed bench for idma_legacy_mchan_arbiter (4 channels, tracker depth 8).
// Completion order is checked against a queue of granted channel indices.
module tb_idma_legacy_mchan_arbiter;

  logic                                  clk;
  logic                                  rst;
  idma_legacy_mchan_pkg::burst_req_t [3:0] chan_req;
  logic [3:0]                            chan_valid;
  logic [3:0]                            chan_ready;
  logic [3:0]                            chan_complete;
  logic [3:0][3:0]                       chan_outstanding;
  logic [3:0]                            chan_idle;
  idma_legacy_mchan_pkg::burst_req_t     be_req;
  logic                                  be_valid;
  logic                                  be_ready;
  logic                                  be_complete;
  logic                                  be_idle;
  logic                                  idle;
  logic                                  err;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [3:0] exp_oh [8];
  logic [1:0] exp_ch [8];

  idma_legacy_mchan_arbiter dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .chan_req_i         (chan_req),
    .chan_valid_i       (chan_valid),
    .chan_ready_o       (chan_ready),
    .chan_complete_o    (chan_complete),
    .chan_outstanding_o (chan_outstanding),
    .chan_idle_o        (chan_idle),
    .be_req_o           (be_req),
    .be_valid_o         (be_valid),
    .be_ready_i         (be_ready),
    .be_complete_i      (be_complete),
    .be_idle_i          (be_idle),
    .idle_o             (idle),
    .err_o              (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: next completion pulse must belong to the oldest granted channel
  task automatic chk_cpl(input string tag);
    logic [1:0] ch;
    logic [3:0] oh;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected no completion queued", tag, chan_complete);
    end else begin
      ch = exp_q.pop_front();
      oh = 4'b0001 << ch;
      chk(tag, 32'(chan_complete), 32'(oh));
    end
  endtask

  initial begin
    exp_oh = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_ch = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst         = 1'b1;
    be_ready    = 1'b1;
    be_complete = 1'b0;
    be_idle     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chan_req[c]           = '0;
      chan_req[c].num_bytes = 32'($urandom_range(1, 255));
      chan_req[c].src_addr  = $urandom;
      chan_req[c].dst_addr  = $urandom;
    end
    chan_valid = 4'b1111;

    // reset state, requests must not be accepted while reset is high
    cyc();
    cyc();
    chk("rst_ready", 32'(chan_ready), 32'h0);
    chk("rst_be_valid", 32'(be_valid), 32'h0);
    chk("rst_be_req", 32'(be_req.num_bytes), 32'h0);
    chk("rst_complete", 32'(chan_complete), 32'h0);
    chk("rst_outstanding", 32'(chan_outstanding), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chan_valid = 4'b0000;
    rst = 1'b0;
    cyc();

    // single 64-byte request on channel 1
    chan_req[1].num_bytes = 32'd64;
    chan_valid = 4'b0010;
    settle();
    chk("t1_ready", 32'(chan_ready), 32'h2);
    exp_q.push_back(2'd1);
    cyc();
    chan_valid = 4'b0000;
    chk("t1_be_valid", 32'(be_valid), 32'h1);
    chk("t1_be_bytes", 32'(be_req.num_bytes), 32'd64);
    chk("t1_be_src", be_req.src_addr, chan_req[1].src_addr);
    chk("t1_outst1", 32'(chan_outstanding[1]), 32'h1);
    chk("t1_idle1", 32'(chan_idle[1]), 32'h0);
    cyc();
    chk("t1_be_valid_drop", 32'(be_valid), 32'h0);
    for (int i = 0; i < 8; i++) cyc();
    be_complete = 1'b1;
    cyc();
    be_complete = 1'b0;
    chk_cpl("t1_complete");
    chk("t1_outst1_zero", 32'(chan_outstanding[1]), 32'h0);
    cyc();
    chk("t1_complete_gone", 32'(chan_complete), 32'h0);
    chk("t1_all_idle", 32'(chan_idle), 32'hf);

    // all channels valid, round-robin from pointer 2, backend never completes
    chan_req[1].num_bytes = 32'd16;
    chan_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("t2_grant%0d", i), 32'(chan_ready), 32'(exp_oh[i]));
      exp_q.push_back(exp_ch[i]);
      cyc();
    end
    settle();
    chk("t2_full_block", 32'(chan_ready), 32'h0);
    cyc();
    settle();
    chk("t2_full_block2", 32'(chan_ready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t2_outst%0d", c), 32'(chan_outstanding[c]), 32'h2);
    end

    // completion while full: push and pop channel 2 in the same cycle
    be_complete = 1'b1;
    settle();
    chk("t3_full_pushpop_ready", 32'(chan_ready), 32'h4);
    exp_q.push_back(2'd2);
    cyc();
    be_complete = 1'b0;
    chan_valid  = 4'b0000;
    chk_cpl("t3_complete");
    chk("t3_outst2_same", 32'(chan_outstanding[2]), 32'h2);
    chk("t3_be_valid", 32'(be_valid), 32'h1);
    settle();
    chk("t3_still_full", 32'(chan_ready), 32'h0);

    // drain seven entries, leaving one transfer of channel 2 in flight
    for (int i = 0; i < 7; i++) begin
      be_complete = 1'b1;
      cyc();
      chk_cpl($sformatf("t3_drain%0d", i));
    end
    be_complete = 1'b0;
    cyc();
    chk("t3_outst2_one", 32'(chan_outstanding[2]), 32'h1);
    chk("t3_outst0_zero", 32'(chan_outstanding[0]), 32'h0);

    // zero-length request on channel 2 waits for its outstanding transfer
    chan_req[2].num_bytes = 32'd0;
    chan_valid = 4'b0100;
    settle();
    chk("t4_zero_blocked", 32'(chan_ready), 32'h0);
    cyc();
    be_complete = 1'b1;
    settle();
    chk("t4_zero_blocked_cpl", 32'(chan_ready), 32'h0);
    cyc();
    be_complete = 1'b0;
    chk_cpl("t4_last_cpl");
    chk("t4_outst2_zero", 32'(chan_outstanding[2]), 32'h0);
    settle();
    chk("t4_zero_ready", 32'(chan_ready), 32'h4);
    exp_q.push_back(2'd2);
    cyc();
    chan_valid = 4'b0000;
    chan_req[2].num_bytes = 32'd8;
    chk_cpl("t4_zero_pulse");
    chk("t4_no_be_valid", 32'(be_valid), 32'h0);
    chk("t4_outst2_still_zero", 32'(chan_outstanding[2]), 32'h0);
    chk("t4_err", 32'(err), 32'h0);

    // channels 0 and 3 interleaved; pointer is 3 here
    chan_valid = 4'b1001;
    settle();
    chk("t5_g0", 32'(chan_ready), 32'h8);
    exp_q.push_back(2'd3);
    cyc();
    settle();
    chk("t5_g1", 32'(chan_ready), 32'h1);
    exp_q.push_back(2'd0);
    cyc();
    chan_valid  = 4'b0000;
    be_complete = 1'b1;
    cyc();
    chk_cpl("t5_cpl_ch3");
    chk("t5_outst3_zero", 32'(chan_outstanding[3]), 32'h0);
    chan_valid = 4'b0001;
    settle();
    chk("t5_pushpop_ready", 32'(chan_ready), 32'h1);
    exp_q.push_back(2'd0);
    cyc();
    chk_cpl("t5_cpl_ch0");
    chk("t5_outst0_same", 32'(chan_outstanding[0]), 32'h1);
    chan_valid  = 4'b1001;
    be_complete = 1'b0;
    settle();
    chk("t5_g2", 32'(chan_ready), 32'h8);
    exp_q.push_back(2'd3);
    cyc();
    chan_valid  = 4'b0000;
    be_complete = 1'b1;
    cyc();
    chk_cpl("t5_cpl_ch0b");
    cyc();
    be_complete = 1'b0;
    chk_cpl("t5_cpl_ch3b");
    cyc();
    chk("t5_idle", 32'(idle), 32'h1);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'h0);

    // completion with an empty tracker sets a sticky error
    be_complete = 1'b1;
    cyc();
    be_complete = 1'b0;
    chk("t6_err", 32'(err), 32'h1);
    chk("t6_no_pulse", 32'(chan_complete), 32'h0);
    cyc();
    cyc();
    chk("t6_err_sticky", 32'(err), 32'h1);

    // asynchronous reset in the middle of a burst
    chan_valid = 4'b1111;
    cyc();
    chk("t7_be_valid", 32'(be_valid), 32'h1);
    rst = 1'b1;
    settle();
    chk("t7_rst_be_valid", 32'(be_valid), 32'h0);
    chk("t7_rst_ready", 32'(chan_ready), 32'h0);
    chk("t7_rst_outst", 32'(chan_outstanding), 32'h0);
    chk("t7_rst_err", 32'(err), 32'h0);
    chk("t7_rst_be_req", 32'(be_req.num_bytes), 32'h0);
    chan_valid = 4'b0000;
    cyc();
    rst = 1'b0;
    cyc();
    be_complete = 1'b1;
    cyc();
    be_complete = 1'b0;
    chk("t7_late_cpl_err", 32'(err), 32'h1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
